// File: rtl/u_col_rotator.sv
// Givens rotation of one adjacent column pair (col, col+1) of the U store.
// Reads both columns in one access, rotates every row with saturation, and writes the pair back.
module u_col_rotator #(
  parameter int data_width = 24,
  parameter int no_of_row  = 3,
  parameter int addr_width = 6
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  input  logic [2:0]                                    col,
  input  logic signed [data_width-1:0]                  cos_in,
  input  logic signed [data_width-1:0]                  sin_in,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          err,
  output logic                                          mem_we,
  output logic [addr_width-1:0]                         mem_addr,
  output logic [2*data_width*(2**no_of_row)-1:0]        mem_wdata,
  input  logic [2*data_width*(2**no_of_row)-1:0]        mem_rdata
);

  localparam int ROWS   = 2**no_of_row;
  localparam int HALF   = data_width * ROWS;
  localparam int PROD_W = 2 * data_width;
  localparam int SUM_W  = PROD_W + 1;
  localparam int FRAC   = 16;

  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-data_width+1){1'b0}}, {(data_width-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W-data_width+1){1'b1}}, {(data_width-1){1'b0}}};
  localparam logic signed [data_width-1:0] OUT_MAX = {1'b0, {(data_width-1){1'b1}}};
  localparam logic signed [data_width-1:0] OUT_MIN = {1'b1, {(data_width-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                                   state_q, state_d;
  logic [2:0]                               col_q, col_d;
  logic signed [data_width-1:0]             c_q, c_d;
  logic signed [data_width-1:0]             s_q, s_d;
  logic [ROWS-1:0][data_width-1:0]          h_res_q, h_res_d;
  logic [ROWS-1:0][data_width-1:0]          l_res_q, l_res_d;
  logic                                     err_q, err_d;
  logic [5:0]                               pair_addr;

  // Arithmetic shift floors toward minus infinity before the clamp.
  function automatic logic signed [data_width-1:0] sat_shift(
    input logic signed [SUM_W-1:0] acc
  );
    logic signed [SUM_W-1:0] shifted;
    shifted = acc >>> FRAC;
    if (shifted > SAT_MAX)      sat_shift = OUT_MAX;
    else if (shifted < SAT_MIN) sat_shift = OUT_MIN;
    else                        sat_shift = data_width'(shifted);
  endfunction

  function automatic logic signed [data_width-1:0] rot_h(
    input logic signed [data_width-1:0] c,
    input logic signed [data_width-1:0] s,
    input logic signed [data_width-1:0] h,
    input logic signed [data_width-1:0] l
  );
    logic signed [PROD_W-1:0] p_ch;
    logic signed [PROD_W-1:0] p_sl;
    logic signed [SUM_W-1:0]  acc;
    p_ch  = PROD_W'(c) * PROD_W'(h);
    p_sl  = PROD_W'(s) * PROD_W'(l);
    acc   = SUM_W'(p_ch) - SUM_W'(p_sl);
    rot_h = sat_shift(acc);
  endfunction

  function automatic logic signed [data_width-1:0] rot_l(
    input logic signed [data_width-1:0] c,
    input logic signed [data_width-1:0] s,
    input logic signed [data_width-1:0] h,
    input logic signed [data_width-1:0] l
  );
    logic signed [PROD_W-1:0] p_sh;
    logic signed [PROD_W-1:0] p_cl;
    logic signed [SUM_W-1:0]  acc;
    p_sh  = PROD_W'(s) * PROD_W'(h);
    p_cl  = PROD_W'(c) * PROD_W'(l);
    acc   = SUM_W'(p_sh) + SUM_W'(p_cl);
    rot_l = sat_shift(acc);
  endfunction

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    c_d     = c_q;
    s_d     = s_q;
    h_res_d = h_res_q;
    l_res_d = l_res_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (col == 3'd7) begin
            err_d = 1'b1;
          end else begin
            col_d   = col;
            c_d     = cos_in;
            s_d     = sin_in;
            state_d = RD;
          end
        end
      end
      RD:   state_d = CAP;
      CAP: begin
        // Read data for the pair arrives this cycle; lower half is column col.
        for (int i = 0; i < ROWS; i++) begin
          h_res_d[i] = rot_h(c_q, s_q,
                             signed'(mem_rdata[i*data_width +: data_width]),
                             signed'(mem_rdata[HALF + i*data_width +: data_width]));
          l_res_d[i] = rot_l(c_q, s_q,
                             signed'(mem_rdata[i*data_width +: data_width]),
                             signed'(mem_rdata[HALF + i*data_width +: data_width]));
        end
        state_d = WR;
      end
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      c_q     <= '0;
      s_q     <= '0;
      h_res_q <= '0;
      l_res_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      c_q     <= c_d;
      s_q     <= s_d;
      h_res_q <= h_res_d;
      l_res_q <= l_res_d;
      err_q   <= err_d;
    end
  end

  assign pair_addr = {1'b1, col_q, 2'b00};

  always_comb begin
    busy      = (state_q == RD) || (state_q == CAP) || (state_q == WR);
    done      = (state_q == DONE);
    err       = err_q;
    mem_we    = (state_q == WR);
    mem_addr  = '0;
    mem_wdata = '0;
    if ((state_q == RD) || (state_q == WR)) mem_addr = addr_width'(pair_addr);
    if (state_q == WR) mem_wdata = {l_res_q, h_res_q};
  end

endmodule

// File: tb/tb_u_col_rotator.sv
// Directed bench for u_col_rotator: a column-pair store model, a queue of expected
// writeback/done/err events and a negedge monitor that pops and compares them.
module tb_u_col_rotator;

  localparam int DW = 24;
  localparam int MW = 384;

  logic                 clk = 1'b0;
  logic                 rst, start;
  logic [2:0]           col;
  logic signed [DW-1:0] cos_in, sin_in;
  logic                 busy, done, err, mem_we;
  logic [5:0]           mem_addr;
  logic [MW-1:0]        mem_wdata, mem_rdata;

  logic [7:0][DW-1:0]   store [8];

  typedef struct {
    int           kind;   // 0 = write, 1 = done, 2 = err
    logic [5:0]   addr;
    logic [MW-1:0] data;
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;
  int   mon_kind;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  u_col_rotator dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .col       (col),
    .cos_in    (cos_in),
    .sin_in    (sin_in),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Store model: one-cycle read latency, pair packed as {col+1, col}.
  always @(posedge clk) begin
    if (mem_addr[5] && !mem_we)
      mem_rdata <= {store[mem_addr[4:2] + 3'd1], store[mem_addr[4:2]]};
    if (mem_we) begin
      store[mem_addr[4:2]]        <= mem_wdata[191:0];
      store[mem_addr[4:2] + 3'd1] <= mem_wdata[383:192];
    end
  end

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we === 1'b1 || done === 1'b1 || err === 1'b1) begin
      mon_kind = (mem_we === 1'b1) ? 0 : ((done === 1'b1) ? 1 : 2);
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_event: got kind %0d expected no event", mon_kind);
      end else begin
        mon_e = sb.pop_front();
        check("evt_kind", MW'(mon_kind), MW'(mon_e.kind));
        if (mon_kind == 0 && mon_e.kind == 0) begin
          check("wr_addr", MW'(mem_addr), MW'(mon_e.addr));
          check("wr_data", mem_wdata, mon_e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_evt(input int kind, input logic [5:0] addr, input logic [MW-1:0] data);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic init_identity();
    for (int j = 0; j < 8; j++) begin
      store[j]    = '0;
      store[j][j] = 24'h010000;
    end
  endtask

  task automatic init_zero();
    for (int j = 0; j < 8; j++) store[j] = '0;
  endtask

  task automatic run_rot(input logic [2:0] c_col, input logic signed [DW-1:0] c,
                         input logic signed [DW-1:0] s, input logic [7:0][DW-1:0] eh,
                         input logic [7:0][DW-1:0] el, input bit repulse, input bit scramble);
    push_evt(0, {1'b1, c_col, 2'b00}, {el, eh});
    push_evt(1, '0, '0);
    start = 1'b1; col = c_col; cos_in = c; sin_in = s;
    tick();
    start = 1'b0;
    if (scramble) begin
      col = 3'd5; cos_in = 24'h123456; sin_in = 24'h654321;
    end
    check("rd_busy", MW'(busy), MW'(1'b1));
    check("rd_addr", MW'(mem_addr), MW'({1'b1, c_col, 2'b00}));
    check("rd_we", MW'(mem_we), MW'(1'b0));
    tick();
    check("cap_busy", MW'(busy), MW'(1'b1));
    check("cap_addr_en", MW'(mem_addr[5]), MW'(1'b0));
    if (repulse) begin
      start = 1'b1; col = c_col;
    end
    tick();
    start = 1'b0;
    check("wr_busy", MW'(busy), MW'(1'b1));
    check("wr_we", MW'(mem_we), MW'(1'b1));
    tick();
    check("done_pulse", MW'(done), MW'(1'b1));
    check("done_busy", MW'(busy), MW'(1'b0));
    check("done_we", MW'(mem_we), MW'(1'b0));
    tick();
    check("idle_done", MW'(done), MW'(1'b0));
    check("idle_busy", MW'(busy), MW'(1'b0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0][DW-1:0] eh, el;
    rst = 1'b1; start = 1'b0; col = '0; cos_in = '0; sin_in = '0;
    init_identity();
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", MW'(busy), MW'(1'b0));
    check("rst_done", MW'(done), MW'(1'b0));
    check("rst_err", MW'(err), MW'(1'b0));
    check("rst_we", MW'(mem_we), MW'(1'b0));
    check("rst_addr", MW'(mem_addr), MW'(6'd0));
    check("rst_wdata", mem_wdata, '0);

    // Identity, inputs scrambled after acceptance.
    eh = '0; el = '0;
    eh[0] = 24'h010000; el[1] = 24'h010000;
    run_rot(3'd0, 24'sd65536, 24'sd0, eh, el, 1'b0, 1'b1);

    // 90 degrees on column pair 2/3.
    init_identity();
    eh = '0; el = '0;
    eh[3] = 24'hFF0000; el[2] = 24'h010000;
    run_rot(3'd2, 24'sd0, 24'sd65536, eh, el, 1'b0, 1'b0);

    // Positive and negative saturation, c = s = 1.0.
    init_zero();
    store[4][0] = 24'h7FFFFF; store[5][0] = 24'h7FFFFF;
    store[4][1] = 24'h800000; store[5][1] = 24'h800000;
    store[4][2] = 24'h800000; store[5][2] = 24'h7FFFFF;
    eh = '0; el = '0;
    el[0] = 24'h7FFFFF;
    el[1] = 24'h800000;
    eh[2] = 24'h800000; el[2] = 24'hFFFFFF;
    run_rot(3'd4, 24'sd65536, 24'sd65536, eh, el, 1'b0, 1'b0);

    // Floor truncation with c = s = 0.5; start re-pulsed in CAP must be ignored.
    init_zero();
    store[1][0] = 24'h000001;
    store[1][1] = 24'hFFFFFF;
    store[1][3] = 24'h000003; store[2][3] = 24'h000001;
    eh = '0; el = '0;
    eh[1] = 24'hFFFFFF; el[1] = 24'hFFFFFF;
    eh[3] = 24'h000001; el[3] = 24'h000002;
    run_rot(3'd1, 24'sd32768, 24'sd32768, eh, el, 1'b1, 1'b0);

    // Invalid column.
    push_evt(2, '0, '0);
    start = 1'b1; col = 3'd7; cos_in = 24'sd65536; sin_in = 24'sd0;
    tick();
    start = 1'b0;
    check("err_pulse", MW'(err), MW'(1'b1));
    check("err_busy", MW'(busy), MW'(1'b0));
    check("err_we", MW'(mem_we), MW'(1'b0));
    check("err_addr_en", MW'(mem_addr[5]), MW'(1'b0));
    tick();
    check("err_clear", MW'(err), MW'(1'b0));
    check("err_no_busy", MW'(busy), MW'(1'b0));

    // Reset during CAP aborts without a write.
    init_identity();
    start = 1'b1; col = 3'd3; cos_in = 24'sd65536; sin_in = 24'sd0;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", MW'(busy), MW'(1'b0));
    check("abort_we", MW'(mem_we), MW'(1'b0));
    check("abort_addr", MW'(mem_addr), MW'(6'd0));
    check("abort_wdata", mem_wdata, '0);
    repeat (4) tick();
    check("abort_idle", MW'(busy), MW'(1'b0));

    // Reset wins over start in the same cycle.
    rst = 1'b1; start = 1'b1; col = 3'd1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst_prio_busy", MW'(busy), MW'(1'b0));
    tick();
    check("rst_prio_idle", MW'(busy), MW'(1'b0));

    for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/u_col_rotator.md
U_COL_ROTATOR -- requirements
Module: u_col_rotator

Interface
REQ-001 SHALL have parameter data_width, default 24, element width, signed Q8.16 (65536 = 1.0).
REQ-002 SHALL have parameter no_of_row, default 3, log2 of row count (8 rows).
REQ-003 SHALL have parameter addr_width, default 6, matrix-store address width.
REQ-004 clk  input  1  sole clock, all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle request, sampled only in IDLE.
REQ-007 col  input  3  left column index; pair is (col, col+1).
REQ-008 cos_in, sin_in  input  data_width each  signed Q8.16 rotation coefficients c, s.
REQ-009 busy  output  1  high while a rotation is in flight.
REQ-010 done  output  1  one-cycle pulse when writeback completes.
REQ-011 err  output  1  one-cycle pulse on a rejected request.
REQ-012 mem_we  output  1  write enable to the U store (1 = write, 0 = read).
REQ-013 mem_addr  output  addr_width  {en, col[2:0], 2'b00}; en = bit 5.
REQ-014 mem_wdata  output  2*data_width*2^no_of_row  write data; lower half = column col, upper half = column col+1; row i at bits [i*dw +: dw] within each half.
REQ-015 mem_rdata  input  same width and packing as mem_wdata  read data from the store, valid one cycle after the read address is presented.

Function
REQ-016 FSM states SHALL be IDLE, RD, CAP, WR, DONE.
REQ-017 In IDLE, start=1 with col<7 SHALL latch col, cos_in and sin_in and go to RD next cycle.
REQ-018 In IDLE, start=1 with col==7 SHALL pulse err for one cycle, stay in IDLE and issue no memory access.
REQ-019 RD SHALL drive mem_addr={1,col,00} with mem_we=0 for exactly one cycle, then go to CAP.
REQ-020 CAP SHALL compute, for each row i, from H=col and L=col+1 columns in mem_rdata:
- H'[i] = (c*H[i] - s*L[i]) >>> 16
- L'[i] = (s*H[i] + c*L[i]) >>> 16
It SHALL register all 16 results at the end of CAP.
REQ-021 Arithmetic SHALL use full-precision 2*data_width-bit signed products and a (2*data_width+1)-bit sum.
REQ-022 The shift SHALL be arithmetic, truncating toward minus infinity.
REQ-023 Each result SHALL saturate to the signed data_width range: max 0x7FFFFF, min 0x800000.
REQ-024 WR SHALL drive mem_we=1 and mem_addr={1,col,00} with mem_wdata={L' packed, H' packed} for exactly one cycle, then go to DONE.
REQ-025 DONE SHALL assert done for one cycle and return to IDLE.
REQ-026 busy SHALL be high in RD, CAP and WR, and low in IDLE and DONE.
REQ-027 Latency SHALL be start edge to done pulse = 4 cycles; back-to-back start is accepted the cycle after DONE.
REQ-028 Outside RD and WR, mem_addr[5] SHALL be 0 and mem_we SHALL be 0.
REQ-029 start asserted while not in IDLE SHALL be ignored, with no err.
REQ-030 Latched col, c and s SHALL NOT change during a rotation, regardless of input changes.

Reset
REQ-031 rst=1 SHALL force IDLE at the next edge and clear busy, done, err, mem_we, mem_addr and mem_wdata to 0.
REQ-032 rst=1 SHALL clear the latched col, c, s and result registers to 0.
REQ-033 rst asserted mid-rotation SHALL abort it with no WR cycle; a partially computed result is never written.
REQ-034 rst SHALL take priority over start in the same cycle.

Verification
REQ-035 Identity rotation: store holds identity; start, col=0, c=65536, s=0 -> one read, then a write with H'=e0 (row0=0x010000) and L'=e1; done 4 cycles after start.
REQ-036 90-degree rotation: col=2, c=0, s=65536 on identity -> H' row3=0xFF0000, others 0; L' row2=0x010000, others 0.
REQ-037 Saturation: H[0]=L[0]=0x7FFFFF, c=s=65536 -> L'[0]=0x7FFFFF and H'[0]=0x000000.
REQ-038 Invalid column: start with col=7 -> err high one cycle; busy, mem_we and mem_addr[5] stay 0; no done.
REQ-039 Busy and reset: start accepted, start re-pulsed in CAP -> ignored, single done; separately, rst in CAP -> no mem_we ever asserted, busy=0 next cycle.
